cache_block_buffer: RTL

Single-clock transfer buffer between a cache controller's memory-side command/buffer ports and the external word-wide memory interface. It accepts one request at a time from the cache, either a block or a single word, read or write. Write data is staged from the cache and then issued word by word to memory. Read data is fetched from memory and staged for the cache to drain. It produces the `ready_req`, `ready_write`, `ready_read` and data signals that the cache controller consumes.

---
 rtl/cache_block_buffer_pkg.sv | 32 +++
 rtl/block_buffer_ram.sv | 29 ++
 rtl/cache_block_buffer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cache_block_buffer_pkg.sv
// Shared types and helpers for the cache-to-memory block transfer buffer.
// Holds the FSM encoding, cache geometry macros and block address helper.
`ifndef BW_BLOCK
`define BW_BLOCK 4
`endif
`ifndef BW_WORD_ADDR
`define BW_WORD_ADDR 16
`endif

package cache_block_buffer_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_FILL  = 3'd1,
    WR_ISSUE = 3'd2,
    RD_ISSUE = 3'd3,
    RD_DRAIN = 3'd4
  } state_t;

  // Clears the in-block word index bits of a word address.
  function automatic logic [31:0] block_base(
    input logic [31:0] add,
    input int unsigned bw_block
  );
    logic [31:0] mask;
    mask = ~((32'd1 << bw_block) - 32'd1);
    return add & mask;
  endfunction

endpackage

// File: rtl/block_buffer_ram.sv
// Staging storage for one block: single write port, two async read ports.
// Port a serves memory-side write issue, port b serves the cache drain.
module block_buffer_ram
  import cache_block_buffer_pkg::*;
#(
  parameter int BW_BLOCK = 4
) (
  input  logic                clock_i,
  input  logic                we,
  input  logic [BW_BLOCK-1:0] waddr,
  input  logic [WORD_W-1:0]   wdata,
  input  logic [BW_BLOCK-1:0] raddr_a,
  output logic [WORD_W-1:0]   rdata_a,
  input  logic [BW_BLOCK-1:0] raddr_b,
  output logic [WORD_W-1:0]   rdata_b
);

  localparam int DEPTH = 1 << BW_BLOCK;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/cache_block_buffer.sv
// Transfer buffer between cache command ports and word-wide memory.
// One block or single-word request at a time; FSM and counters live here.
module cache_block_buffer
  import cache_block_buffer_pkg::*;
#(
  parameter int BW_BLOCK = `BW_BLOCK,
  parameter int BW_ADDR  = `BW_WORD_ADDR
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               req_i,
  input  logic               req_block_i,
  input  logic               rw_i,
  input  logic [BW_ADDR-1:0] add_i,
  output logic               ready_req_o,
  input  logic               write_i,
  input  logic [WORD_W-1:0]  data_i,
  output logic               ready_write_o,
  input  logic               read_i,
  output logic [WORD_W-1:0]  data_o,
  output logic               ready_read_o,
  output logic               mem_req_o,
  output logic               mem_rw_o,
  output logic [BW_ADDR-1:0] mem_addr_o,
  output logic [WORD_W-1:0]  mem_data_o,
  input  logic               mem_ack_i,
  input  logic               mem_rvalid_i,
  input  logic [WORD_W-1:0]  mem_data_i
);

  localparam int CW    = BW_BLOCK + 1;
  localparam int DEPTH = 1 << BW_BLOCK;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]      fill_cnt;
  logic [CW-1:0]      iss_cnt;
  logic [CW-1:0]      rcv_cnt;
  logic [CW-1:0]      pop_cnt;
  logic [CW-1:0]      n_q;
  logic [BW_ADDR-1:0] addr_q;
  logic [BW_ADDR-1:0] base_d;

  logic accept;
  logic rd_state;
  logic fill_fire;
  logic iss_fire;
  logic iss_last;
  logic rcv_fire;
  logic pop_fire;

  logic                ram_we;
  logic [BW_BLOCK-1:0] ram_waddr;
  logic [WORD_W-1:0]   ram_wdata;
  logic [WORD_W-1:0]   iss_word;
  logic [WORD_W-1:0]   pop_word;

  assign rd_state = (state_q == RD_ISSUE) ||
                    (state_q == RD_DRAIN);

  assign ready_req_o   = (state_q == IDLE);
  assign ready_write_o = (state_q == WR_FILL);
  assign ready_read_o  = rd_state && (pop_cnt < rcv_cnt);
  assign mem_req_o     = (state_q == WR_ISSUE) ||
                         (state_q == RD_ISSUE);
  assign mem_rw_o      = (state_q == WR_ISSUE);

  assign accept    = (state_q == IDLE) && req_i;
  assign fill_fire = (state_q == WR_FILL) && write_i;
  assign iss_fire  = mem_req_o && mem_ack_i;
  assign iss_last  = iss_fire && (iss_cnt == n_q - CW'(1));
  // Returns past the Nth word belong to nobody and are dropped.
  assign rcv_fire  = rd_state && mem_rvalid_i &&
                     (rcv_cnt < n_q);
  assign pop_fire  = read_i && ready_read_o;

  assign base_d = BW_ADDR'(block_base(32'(add_i), BW_BLOCK));

  assign mem_addr_o = mem_req_o ?
    (addr_q | BW_ADDR'(iss_cnt[BW_BLOCK-1:0])) : '0;
  assign mem_data_o = mem_rw_o ? iss_word : '0;
  assign data_o     = ready_read_o ? pop_word : '0;

  assign ram_we    = fill_fire || rcv_fire;
  assign ram_waddr = fill_fire ? fill_cnt[BW_BLOCK-1:0]
                               : rcv_cnt[BW_BLOCK-1:0];
  assign ram_wdata = fill_fire ? data_i : mem_data_i;

  block_buffer_ram #(
    .BW_BLOCK(BW_BLOCK)
  ) u_ram (
    .clock_i(clock_i),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .raddr_a(iss_cnt[BW_BLOCK-1:0]),
    .rdata_a(iss_word),
    .raddr_b(pop_cnt[BW_BLOCK-1:0]),
    .rdata_b(pop_word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) state_d = rw_i ? WR_FILL : RD_ISSUE;
      end
      WR_FILL: begin
        if (fill_fire && (fill_cnt == n_q - CW'(1)))
          state_d = WR_ISSUE;
      end
      WR_ISSUE: begin
        if (iss_last) state_d = IDLE;
      end
      RD_ISSUE: begin
        if (iss_last) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (pop_fire && (pop_cnt == n_q - CW'(1)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      n_q      <= '0;
      fill_cnt <= '0;
      iss_cnt  <= '0;
      rcv_cnt  <= '0;
      pop_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_block_i ? base_d : add_i;
        n_q      <= req_block_i ? CW'(DEPTH) : CW'(1);
        fill_cnt <= '0;
        iss_cnt  <= '0;
        rcv_cnt  <= '0;
        pop_cnt  <= '0;
      end else begin
        if (fill_fire) fill_cnt <= fill_cnt + CW'(1);
        if (iss_fire)  iss_cnt  <= iss_cnt + CW'(1);
        if (rcv_fire)  rcv_cnt  <= rcv_cnt + CW'(1);
        if (pop_fire)  pop_cnt  <= pop_cnt + CW'(1);
      end
    end
  end

endmodule
